// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues imem requests, fills the IF/ID slot.
// Optional HLT detection is enabled by defining FETCH_HALT_DETECT_EN.
module fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [15:0] branch_target,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_rdy,
   input  logic [15:0] imem_data,
   output logic        instr_valid,
   output logic [15:0] instr_out,
   output logic [15:0] pc_out,
   output logic [15:0] pc_plus2,
   output logic        halted
);

   typedef enum logic {
      FETCH = 1'b0,
      HALT  = 1'b1
   } state_t;

   state_t      state;
   logic [15:0] fpc;
   logic        buf_valid;
   logic [15:0] buf_instr;
   logic [15:0] buf_pc;

   logic        accept;
   logic        slot_free;
   logic        hlt_word;

   // A full skid buffer or a pending redirect blocks new requests.
   assign imem_req  = (state == FETCH) && !buf_valid && !branch_taken && !rst;
   assign imem_addr = fpc;
   assign accept    = imem_req && imem_rdy;
   assign slot_free = !instr_valid || !stall;
   assign pc_plus2  = pc_out + 16'd2;

`ifdef FETCH_HALT_DETECT_EN
   assign hlt_word = (imem_data[15:12] == 4'hF);
   assign halted   = (state == HALT);
`else
   assign hlt_word = 1'b0;
   assign halted   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state       <= FETCH;
         fpc         <= RESET_PC;
         buf_valid   <= 1'b0;
         buf_instr   <= 16'h0000;
         buf_pc      <= 16'h0000;
         instr_valid <= 1'b0;
         instr_out   <= 16'h0000;
         pc_out      <= 16'h0000;
      end else if (branch_taken) begin
         state       <= FETCH;
         fpc         <= branch_target;
         buf_valid   <= 1'b0;
         instr_valid <= 1'b0;
      end else if (accept) begin
         fpc <= fpc + 16'd2;
         if (slot_free) begin
            instr_out   <= imem_data;
            pc_out      <= fpc;
            instr_valid <= 1'b1;
         end else begin
            buf_instr <= imem_data;
            buf_pc    <= fpc;
            buf_valid <= 1'b1;
         end
         if (hlt_word)
            state <= HALT;
      end else if (buf_valid && !stall) begin
         // Drain: accept is impossible here since imem_req is low while the buffer is full.
         instr_out   <= buf_instr;
         pc_out      <= buf_pc;
         instr_valid <= 1'b1;
         buf_valid   <= 1'b0;
      end else if (!stall) begin
         instr_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; expectations follow FETCH_HALT_DETECT_EN if defined.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        branch_taken;
   logic [15:0] branch_target;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_rdy;
   logic [15:0] imem_data;
   logic        instr_valid;
   logic [15:0] instr_out;
   logic [15:0] pc_out;
   logic [15:0] pc_plus2;
   logic        halted;
   logic        hlt_force;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // Memory returns tag 4'hA over the low address bits, or a HLT word when forced.
   assign imem_data = hlt_force ? 16'hF000 : {4'hA, imem_addr[11:0]};

   fetch_unit #(.RESET_PC(16'h0000)) dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_rdy     (imem_rdy),
      .imem_data    (imem_data),
      .instr_valid  (instr_valid),
      .instr_out    (instr_out),
      .pc_out       (pc_out),
      .pc_plus2     (pc_plus2),
      .halted       (halted)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
      imem_rdy = 1'b1; hlt_force = 1'b0;

      // Reset cycle
      next_cycle;
      @(negedge clk);
      check("rst_req",    {15'd0, imem_req},    16'h0000);
      check("rst_addr",   imem_addr,            16'h0000);
      check("rst_valid",  {15'd0, instr_valid}, 16'h0000);
      check("rst_instr",  instr_out,            16'h0000);
      check("rst_pc",     pc_out,               16'h0000);
      check("rst_pc2",    pc_plus2,             16'h0002);
      check("rst_halted", {15'd0, halted},      16'h0000);

      // Sequential fetch
      next_cycle; rst = 1'b0;
      @(negedge clk);
      check("a0_req",   {15'd0, imem_req},    16'h0001);
      check("a0_addr",  imem_addr,            16'h0000);
      check("a0_valid", {15'd0, instr_valid}, 16'h0000);
      next_cycle; @(negedge clk);
      check("a1_addr",  imem_addr,            16'h0002);
      check("a1_valid", {15'd0, instr_valid}, 16'h0001);
      check("a1_pc",    pc_out,               16'h0000);
      check("a1_pc2",   pc_plus2,             16'h0002);
      check("a1_instr", instr_out,            16'hA000);
      next_cycle; @(negedge clk);
      check("a2_addr", imem_addr, 16'h0004);
      check("a2_pc",   pc_out,    16'h0002);
      check("a2_pc2",  pc_plus2,  16'h0004);

      // Stall with full slot: one more word goes to the skid buffer
      next_cycle; stall = 1'b1;
      @(negedge clk);
      check("a3_addr", imem_addr,         16'h0006);
      check("a3_pc",   pc_out,            16'h0004);
      check("a3_pc2",  pc_plus2,          16'h0006);
      check("a3_req",  {15'd0, imem_req}, 16'h0001);
      for (int i = 0; i < 2; i++) begin
         next_cycle; @(negedge clk);
         check("stall_req",   {15'd0, imem_req}, 16'h0000);
         check("stall_pc",    pc_out,            16'h0004);
         check("stall_instr", instr_out,         16'hA004);
         check("stall_addr",  imem_addr,         16'h0008);
      end
      next_cycle; stall = 1'b0;
      @(negedge clk);
      check("drain_req", {15'd0, imem_req}, 16'h0000);
      next_cycle; @(negedge clk);
      check("skid_pc",    pc_out,            16'h0006);
      check("skid_instr", instr_out,         16'hA006);
      check("skid_req",   {15'd0, imem_req}, 16'h0001);
      check("skid_addr",  imem_addr,         16'h0008);

      // Advance to 16'h0010, then insert three wait states
      next_cycle; next_cycle; next_cycle;
      next_cycle; imem_rdy = 1'b0;
      @(negedge clk);
      check("ws_addr0", imem_addr, 16'h0010);
      check("ws_pc0",   pc_out,    16'h000E);
      for (int i = 0; i < 2; i++) begin
         next_cycle; @(negedge clk);
         check("ws_addr",  imem_addr,            16'h0010);
         check("ws_valid", {15'd0, instr_valid}, 16'h0000);
         check("ws_req",   {15'd0, imem_req},    16'h0001);
      end
      next_cycle; imem_rdy = 1'b1;
      @(negedge clk);
      check("ws_rdy_addr",  imem_addr,            16'h0010);
      check("ws_rdy_valid", {15'd0, instr_valid}, 16'h0000);

      // Redirect with a return in the same cycle
      next_cycle; branch_taken = 1'b1; branch_target = 16'h0040;
      @(negedge clk);
      check("ws_out_valid", {15'd0, instr_valid}, 16'h0001);
      check("ws_out_pc",    pc_out,               16'h0010);
      check("ws_out_instr", instr_out,            16'hA010);
      check("br_req",       {15'd0, imem_req},    16'h0000);
      next_cycle; branch_taken = 1'b0;
      @(negedge clk);
      check("br_valid", {15'd0, instr_valid}, 16'h0000);
      check("br_addr",  imem_addr,            16'h0040);
      check("br_req1",  {15'd0, imem_req},    16'h0001);
      next_cycle; branch_taken = 1'b1; branch_target = 16'h0020;
      @(negedge clk);
      check("br_pc",    pc_out,               16'h0040);
      check("br_instr", instr_out,            16'hA040);
      check("br_valid1", {15'd0, instr_valid}, 16'h0001);

      // HLT word at 16'h0020
      next_cycle; branch_taken = 1'b0; hlt_force = 1'b1;
      @(negedge clk);
      check("hlt_addr", imem_addr, 16'h0020);
      next_cycle; hlt_force = 1'b0;
      @(negedge clk);
      check("hlt_instr", instr_out,            16'hF000);
      check("hlt_pc",    pc_out,               16'h0020);
      check("hlt_valid", {15'd0, instr_valid}, 16'h0001);
      check("hlt_addr2", imem_addr,            16'h0022);
`ifdef FETCH_HALT_DETECT_EN
      check("hlt_halted", {15'd0, halted},   16'h0001);
      check("hlt_req",    {15'd0, imem_req}, 16'h0000);
      next_cycle; @(negedge clk);
      check("hlt_halted2", {15'd0, halted},      16'h0001);
      check("hlt_req2",    {15'd0, imem_req},    16'h0000);
      check("hlt_valid2",  {15'd0, instr_valid}, 16'h0000);
`else
      check("hlt_halted", {15'd0, halted},   16'h0000);
      check("hlt_req",    {15'd0, imem_req}, 16'h0001);
      next_cycle; @(negedge clk);
      check("hlt_next_pc",    pc_out,    16'h0022);
      check("hlt_next_instr", instr_out, 16'hA022);
      check("hlt_halted2",    {15'd0, halted}, 16'h0000);
`endif
      branch_taken = 1'b1; branch_target = 16'h0000;
      next_cycle; branch_taken = 1'b0;
      @(negedge clk);
      check("resume_halted", {15'd0, halted},      16'h0000);
      check("resume_addr",   imem_addr,            16'h0000);
      check("resume_req",    {15'd0, imem_req},    16'h0001);
      check("resume_valid",  {15'd0, instr_valid}, 16'h0000);

      // Wrap at 16'hFFFE
      branch_taken = 1'b1; branch_target = 16'hFFFE;
      next_cycle; branch_taken = 1'b0;
      @(negedge clk);
      check("wrap_addr0", imem_addr,         16'hFFFE);
      check("wrap_req0",  {15'd0, imem_req}, 16'h0001);
      next_cycle; stall = 1'b1;
      @(negedge clk);
      check("wrap_addr",  imem_addr, 16'h0000);
      check("wrap_pc",    pc_out,    16'hFFFE);
      check("wrap_pc2",   pc_plus2,  16'h0000);
      check("wrap_instr", instr_out, 16'hAFFE);

      // Redirect while stalled with a full buffer clears both slot and buffer
      next_cycle; @(negedge clk);
      check("brst_req0", {15'd0, imem_req}, 16'h0000);
      check("brst_pc0",  pc_out,            16'hFFFE);
      branch_taken = 1'b1; branch_target = 16'h0100;
      next_cycle; branch_taken = 1'b0; stall = 1'b0;
      @(negedge clk);
      check("brst_valid", {15'd0, instr_valid}, 16'h0000);
      check("brst_addr",  imem_addr,            16'h0100);
      check("brst_req",   {15'd0, imem_req},    16'h0001);

      // Reset during an active request drops the return
      rst = 1'b1;
      next_cycle; @(negedge clk);
      check("mrst_valid", {15'd0, instr_valid}, 16'h0000);
      check("mrst_addr",  imem_addr,            16'h0000);
      check("mrst_req",   {15'd0, imem_req},    16'h0000);
      check("mrst_pc",    pc_out,               16'h0000);
      next_cycle; rst = 1'b0;
      @(negedge clk);
      check("mrst_req1",  {15'd0, imem_req}, 16'h0001);
      check("mrst_addr1", imem_addr,         16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 16-bit pipelined core. It owns the architectural fetch PC and drives the instruction-memory request interface. It fills the IF/ID slot with instruction, PC and PC+2. It consumes the redirect (`branch_taken`/`branch_target`) produced by the branch PC-control logic and feeds that logic's `PC_in` through `pc_out`/`pc_plus2`. A one-entry skid buffer absorbs memory returns during downstream stalls.

## Interface
- `RESET_PC`, default 16'h0000: fetch address loaded on reset.

Ports:
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: decode not accepting; IF/ID slot must hold.
- `branch_taken` in 1: redirect request from branch PC control.
- `branch_target` in 16: redirect address; valid when `branch_taken`=1.
- `imem_req` out 1: fetch request, level-sensitive.
- `imem_addr` out 16: fetch address; equals the fetch PC register.
- `imem_rdy` in 1: `imem_data` is valid for this cycle's `imem_addr`.
- `imem_data` in 16: returned instruction word.
- `instr_valid` out 1: IF/ID slot holds a live instruction.
- `instr_out` out 16: IF/ID instruction.
- `pc_out` out 16: address of `instr_out`.
- `pc_plus2` out 16: `pc_out`+2, modulo 2^16.
- `halted` out 1: fetch stopped on a HLT opcode.

## Operation
- **State.**
  - `fpc` (16b), state ∈ {FETCH, HALT}.
  - Skid buffer `{buf_valid, buf_instr, buf_pc}`.
  - IF/ID slot registers.
- **Request.**
  - `imem_req` = (state==FETCH) && !buf_valid && !branch_taken && !rst.
  - `imem_addr` = `fpc` at all times.
- **Accept.** A return is accepted when `imem_req` && `imem_rdy`. The slot is free when !`instr_valid` || !`stall`. On accept:
  - Slot free: slot ← {`imem_data`, `fpc`}, `instr_valid`←1.
  - Slot not free: buffer ← {`imem_data`, `fpc`}, `buf_valid`←1.
  - In both cases `fpc` ← `fpc`+2, wrapping 16'hFFFE→16'h0000.
- **Drain.** When `buf_valid` and `stall`=0: slot ← buffer, `buf_valid`←0.
- **Slot retire.** When `stall`=0 and nothing new is loaded, `instr_valid`←0.
- **HLT.** An accepted word with [15:12]==4'hF moves state to HALT. The HLT word itself is still delivered through slot or buffer. In HALT, `imem_req`=0 and `halted`=1; the buffer and slot still drain normally.
- **Redirect.** `branch_taken`=1 has priority over everything except `rst`, in any state including HALT:
  - `fpc`←`branch_target`.
  - `instr_valid`←0 and `buf_valid`←0.
  - State←FETCH, `halted`←0.
  - Any `imem_rdy` in that cycle is discarded.
  - This applies regardless of `stall`.
- **Reset.** `rst` overrides everything, including mid-request and redirect. An in-flight memory return is dropped.

## Timing
- **Reset values.**
  - `fpc`=`RESET_PC`, state=FETCH, `buf_valid`=0.
  - `instr_valid`=0, `instr_out`=0, `pc_out`=0, `pc_plus2`=16'h0002, `halted`=0.
  - `imem_req`=0 during the reset cycle and 1 on the first cycle after it.
- **Fetch latency.** Accept in cycle N → `instr_valid`/`instr_out` visible in N+1.
- **Throughput.** With `imem_rdy` tied high and `stall`=0, one instruction per cycle.
- **Memory may wait.** `imem_addr` is stable while `imem_req`=1 and `imem_rdy`=0.
- **Redirect timing.** `branch_taken` in cycle N → `imem_addr`=target and `instr_valid`=0 in N+1 → first target instruction valid in N+2 at the earliest.
- **Stall from full slot.** Stall with slot full: at most one further word is accepted (into the buffer), then `imem_req` drops until drain. When `stall` falls, the buffer is in the slot next cycle, and `imem_req` reasserts that same next cycle.
- **Simultaneous events.**
  - Drain and new accept cannot coincide, because `imem_req`=0 while `buf_valid`=1.
  - Redirect together with a HLT return: the redirect wins and state stays FETCH.

## Configuration
- `FETCH_HALT_DETECT_EN`
  - Defined: HLT detection as above; `halted` is functional.
  - Undefined: opcode 4'hF is fetched like any other word, state never leaves FETCH, and `halted` is tied 0.

## Test plan
- **Reset and sequential fetch.** `RESET_PC`=16'h0000, `imem_rdy`=1, release `rst` → `imem_addr` 0,2,4 on consecutive cycles; `pc_out`=0,2,4 one cycle later; `pc_plus2`=2,4,6.
- **Wait states.** `imem_rdy` low for 3 cycles at addr 16'h0010 → `imem_addr` held at 16'h0010; `instr_valid`=0 until the cycle after `imem_rdy` rises; then `pc_out`=16'h0010.
- **Stall and skid.** `stall`=1 with slot full (pc 16'h0004) and one more return (pc 16'h0006) → `imem_req`=0, slot unchanged. `stall`=0 → slot shows 16'h0006 next cycle, and `imem_addr`=16'h0008 is requested that same next cycle.
- **Redirect with outstanding return.** `branch_taken`=1, `branch_target`=16'h0040, with `imem_rdy`=1 in the same cycle → returned word dropped, `instr_valid`=0, next `imem_addr`=16'h0040, and `pc_out`=16'h0040 two cycles after the redirect.
- **HLT** (macro defined). Return 16'hF000 at 16'h0020 → `halted`=1 and `imem_req`=0 next cycle; slot shows 16'hF000/16'h0020. A later redirect to 16'h0000 clears `halted` and resumes fetch. With the macro undefined, fetch continues at 16'h0022.
- **Wrap.** `fpc`=16'hFFFE accepted → next `imem_addr`=16'h0000, `pc_plus2`=16'h0000.
